// File: rtl/flash_pkg.sv
// Shared widths and FSM state type for the flash read arbiter.
package flash_pkg;

  localparam int ADDR_W = 24;
  localparam int CNT_W  = 14;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    STREAM,
    FINISH
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last+1.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int unsigned N = NREQ;

  logic [IDX_W-1:0] cand;

  // Scan requesters in rotating priority order starting after the last winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(last) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one spi_flash read engine between NREQ requesters (round-robin).
module flash_read_arbiter
  import flash_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [24*NREQ-1:0]   req_addr,
  input  logic [14*NREQ-1:0]   req_count,
  output logic [NREQ-1:0]      req_ack,
  output logic [7:0]           req_data,
  output logic [NREQ-1:0]      req_data_valid,
  output logic [NREQ-1:0]      req_done,
  output logic [NREQ-1:0]      req_err,
  output logic                 busy,
  output logic [23:0]          fl_addr,
  output logic [13:0]          fl_byte_count,
  output logic                 fl_start,
  input  logic                 fl_rdy,
  input  logic [7:0]           fl_data,
  input  logic                 fl_data_rdy
);

  localparam int IDX_W = (NREQ > 2) ? 2 : 1;
  localparam int TMO_W = $clog2(START_TIMEOUT + 1);

  state_t state, state_nxt;

  logic [IDX_W-1:0]  last, gidx, arb_idx;
  logic [NREQ-1:0]   arb_grant, gsel;
  logic              arb_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [CNT_W-1:0]  sel_count, rcv, rcv_inc;
  logic [TMO_W-1:0]  tmo;
  logic              err, do_grant, tmo_hit;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_count = req_count[int'(arb_idx)*CNT_W +: CNT_W];
  assign do_grant  = (state == IDLE) && fl_rdy && arb_any;
  assign tmo_hit   = (tmo == TMO_W'(START_TIMEOUT - 1));
  assign rcv_inc   = (rcv == '1) ? rcv : rcv + CNT_W'(1);
  assign gsel      = NREQ'(1) << gidx;

  // Ack is combinational so it coincides with the grant decision; reset masks it.
  assign req_ack = (do_grant && !reset) ? arb_grant : '0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (do_grant) state_nxt = (sel_count == '0) ? FINISH : ISSUE;
      ISSUE:    state_nxt = WAIT_LOW;
      WAIT_LOW: if (!fl_rdy) state_nxt = STREAM;
                else if (tmo_hit) state_nxt = FINISH;
      STREAM:   if (fl_rdy) state_nxt = FINISH;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath: latched request, counters, registered strobes and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last           <= IDX_W'(NREQ - 1);
      gidx           <= '0;
      fl_addr        <= '0;
      fl_byte_count  <= '0;
      fl_start       <= 1'b0;
      busy           <= 1'b0;
      req_data       <= '0;
      req_data_valid <= '0;
      req_done       <= '0;
      req_err        <= '0;
      rcv            <= '0;
      tmo            <= '0;
      err            <= 1'b0;
    end else begin
      fl_start       <= 1'b0;
      req_data_valid <= '0;
      req_done       <= '0;
      req_err        <= '0;
      case (state)
        IDLE: if (do_grant) begin
          gidx          <= arb_idx;
          last          <= arb_idx;
          fl_addr       <= sel_addr;
          fl_byte_count <= sel_count;
          busy          <= 1'b1;
          err           <= 1'b0;
        end
        ISSUE: begin
          fl_start <= 1'b1;
          rcv      <= '0;
          tmo      <= '0;
        end
        WAIT_LOW: if (fl_rdy) begin
          tmo <= tmo + TMO_W'(1);
          if (tmo_hit) err <= 1'b1;
        end
        STREAM: begin
          // A byte arriving with the rdy rise is counted before the mismatch check.
          if (fl_data_rdy) begin
            req_data       <= fl_data;
            req_data_valid <= gsel;
            rcv            <= rcv_inc;
          end
          if (fl_rdy) err <= ((fl_data_rdy ? rcv_inc : rcv) != fl_byte_count);
        end
        FINISH: begin
          req_done <= gsel;
          req_err  <= err ? gsel : '0;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench: flash behavioural model, requesters, event logs, scenario tasks.
module tb_flash_read_arbiter;

  localparam int NREQ = 2;
  localparam int ST   = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [24*NREQ-1:0]  req_addr = '0;
  logic [14*NREQ-1:0]  req_count = '0;
  logic [NREQ-1:0]     req_ack, req_data_valid, req_done, req_err;
  logic [7:0]          req_data;
  logic                busy, fl_start, fl_rdy, fl_data_rdy;
  logic [23:0]         fl_addr;
  logic [13:0]         fl_byte_count;
  logic [7:0]          fl_data;

  flash_read_arbiter #(.NREQ(NREQ), .START_TIMEOUT(ST)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_count(req_count), .req_ack(req_ack), .req_data(req_data),
    .req_data_valid(req_data_valid), .req_done(req_done), .req_err(req_err),
    .busy(busy), .fl_addr(fl_addr), .fl_byte_count(fl_byte_count),
    .fl_start(fl_start), .fl_rdy(fl_rdy), .fl_data(fl_data), .fl_data_rdy(fl_data_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { int idx; int t; } ack_t;
  typedef struct { logic [23:0] a; logic [13:0] c; int t; } start_t;
  typedef struct { int idx; logic [7:0] b; } dat_t;
  typedef struct { int idx; logic err; int t; } done_t;

  ack_t   ack_q[$];
  start_t st_q[$];
  dat_t   dat_q[$];
  done_t  done_q[$];
  logic [7:0] exp_bytes[$];

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  // Event logger
  always @(negedge clk) if (!reset) begin
    if (req_ack != '0)        ack_q.push_back('{onehot_idx(req_ack), cyc});
    if (fl_start)             st_q.push_back('{fl_addr, fl_byte_count, cyc});
    if (req_data_valid != '0) dat_q.push_back('{onehot_idx(req_data_valid), req_data});
    if (req_done != '0)       done_q.push_back('{onehot_idx(req_done), (req_err != '0), cyc});
  end

  // Requesters: hold req_valid until acked, re-request while requests remain.
  int reqs_left[NREQ];
  logic [NREQ-1:0] acked;
  initial begin
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) reqs_left[i] = 0;
    forever begin
      @(negedge clk);
      acked = req_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acked[i] && reqs_left[i] > 0) reqs_left[i]--;
        req_valid[i] = (reqs_left[i] > 0);
      end
    end
  end

  // spi_flash behavioural model
  int mdl_nbytes  = -1;   // <0: return exactly fl_byte_count bytes
  bit mdl_timeout = 0;    // never drop rdy
  bit mdl_same    = 0;    // raise rdy together with last byte
  initial begin
    int nb;
    bit aborted;
    fl_rdy = 1'b1; fl_data_rdy = 1'b0; fl_data = '0;
    forever begin
      @(negedge clk);
      if (!reset && fl_start && !mdl_timeout) begin
        nb = (mdl_nbytes < 0) ? int'(fl_byte_count) : mdl_nbytes;
        aborted = 0;
        fl_rdy = 1'b0;
        for (int b = 0; b < nb; b++) begin
          @(negedge clk);
          fl_data_rdy = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          if (reset) begin aborted = 1; break; end
          fl_data = 8'($urandom);
          fl_data_rdy = 1'b1;
          exp_bytes.push_back(fl_data);
          if (b == nb - 1 && mdl_same) fl_rdy = 1'b1;
        end
        if (!aborted) @(negedge clk);
        fl_data_rdy = 1'b0;
        fl_rdy = 1'b1;
      end
    end
  end

  task automatic clear_logs();
    ack_q.delete(); st_q.delete(); dat_q.delete(); done_q.delete(); exp_bytes.delete();
  endtask

  task automatic set_req(input int i, input logic [23:0] a, input logic [13:0] c);
    req_addr[i*24 +: 24]  = a;
    req_count[i*14 +: 14] = c;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 0;
    repeat (budget) begin
      @(negedge clk);
      if (done_q.size() >= n) begin ok = 1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [55:0] outs;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs = {req_ack, req_data, req_data_valid, req_done, req_err, busy,
            fl_addr, fl_byte_count, fl_start};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, fl_start, req_ack} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset busy=%b start=%b ack=%b want 0", busy, fl_start, req_ack);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    clear_logs();
    mdl_nbytes = 16; mdl_same = 0;
    set_req(0, 24'hABAFAB, 14'd16);
    reqs_left[0] = 1;
    wait_done(1, 400, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL single_done_timeout got=0 want=1"); end
    n_cmp++;
    if (ack_q.size() != 1 || ack_q[0].idx != 0) begin
      n_fail++; $display("FAIL single_ack count=%0d want 1 on req 0", ack_q.size());
    end
    n_cmp++;
    if (st_q.size() != 1 || st_q[0].a !== 24'hABAFAB || st_q[0].c !== 14'd16) begin
      n_fail++; $display("FAIL single_start n=%0d want 1 with addr abafab count 16", st_q.size());
    end
    n_cmp++;
    if (dat_q.size() != 16) begin n_fail++; $display("FAIL single_nbytes got=%0d want=16", dat_q.size()); end
    for (int k = 0; k < dat_q.size() && k < exp_bytes.size(); k++) begin
      n_cmp++;
      if (dat_q[k].idx != 0 || dat_q[k].b !== exp_bytes[k]) begin
        n_fail++; $display("FAIL single_byte%0d got=%h@%0d want=%h@0", k, dat_q[k].b, dat_q[k].idx, exp_bytes[k]);
      end
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0].idx != 0 || done_q[0].err !== 1'b0) begin
      n_fail++; $display("FAIL single_done n=%0d want one done on req 0 err 0", done_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_contention();
    bit ok;
    int rem[NREQ];
    int last_m, c, total;
    int exp_order[$];
    logic [23:0] a[NREQ];
    logic [13:0] n[NREQ];
    int nsum;
    clear_logs();
    mdl_nbytes = -1; mdl_same = 0;
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 24'($urandom); n[i] = 14'($urandom_range(1, 8));
      set_req(i, a[i], n[i]);
      reqs_left[i] = 2; rem[i] = 2;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    // Reference order: every requester always pending until its quota is used.
    last_m = NREQ - 1; total = 2 * NREQ; nsum = 0;
    while (total > 0) begin
      c = -1;
      for (int off = 1; off <= NREQ; off++)
        if (c < 0 && rem[(last_m + off) % NREQ] > 0) c = (last_m + off) % NREQ;
      exp_order.push_back(c); rem[c]--; total--; last_m = c; nsum += int'(n[c]);
    end
    wait_done(exp_order.size(), 1500, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL contention_done_timeout got=%0d want=%0d", done_q.size(), exp_order.size()); end
    for (int k = 0; k < exp_order.size() && k < ack_q.size() && k < st_q.size() && k < done_q.size(); k++) begin
      n_cmp++;
      if (ack_q[k].idx != exp_order[k] || st_q[k].a !== a[exp_order[k]] || done_q[k].idx != exp_order[k] || done_q[k].err !== 1'b0) begin
        n_fail++; $display("FAIL contention_grant%0d got=%0d addr=%h want=%0d addr=%h", k, ack_q[k].idx, st_q[k].a, exp_order[k], a[exp_order[k]]);
      end
      if (k + 1 < st_q.size()) begin
        n_cmp++;
        if (!(done_q[k].t < st_q[k+1].t)) begin
          n_fail++; $display("FAIL contention_order%0d done_t=%0d next_start_t=%0d", k, done_q[k].t, st_q[k+1].t);
        end
      end
    end
    n_cmp++;
    if (dat_q.size() != nsum) begin n_fail++; $display("FAIL contention_nbytes got=%0d want=%0d", dat_q.size(), nsum); end
  endtask

  task automatic test_zero_count();
    bit ok;
    clear_logs();
    set_req(1, 24'h123456, 14'd0);
    reqs_left[1] = 1;
    wait_done(1, 100, ok);
    n_cmp++;
    if (!ok || ack_q.size() != 1 || ack_q[0].idx != 1) begin
      n_fail++; $display("FAIL zero_ack ok=%0d acks=%0d want one ack on req 1", ok, ack_q.size());
    end else begin
      n_cmp++;
      if (done_q[0].idx != 1 || done_q[0].err !== 1'b0 || done_q[0].t - ack_q[0].t != 2) begin
        n_fail++; $display("FAIL zero_done idx=%0d err=%b gap=%0d want 1/0/2", done_q[0].idx, done_q[0].err, done_q[0].t - ack_q[0].t);
      end
    end
    n_cmp++;
    if (st_q.size() != 0) begin n_fail++; $display("FAIL zero_no_start got=%0d want=0", st_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    mdl_timeout = 1;
    set_req(0, 24'h00F00D, 14'd5);
    reqs_left[0] = 1;
    wait_done(1, 200, ok);
    mdl_timeout = 0;
    n_cmp++;
    if (!ok || st_q.size() != 1) begin
      n_fail++; $display("FAIL timeout_seq ok=%0d starts=%0d want 1/1", ok, st_q.size());
    end else begin
      n_cmp++;
      if (done_q[0].t - st_q[0].t != ST + 1 || done_q[0].err !== 1'b1) begin
        n_fail++; $display("FAIL timeout_done gap=%0d err=%b want %0d/1", done_q[0].t - st_q[0].t, done_q[0].err, ST + 1);
      end
    end
    n_cmp++;
    if (dat_q.size() != 0) begin n_fail++; $display("FAIL timeout_nodata got=%0d want=0", dat_q.size()); end
  endtask

  task automatic test_short();
    bit ok;
    clear_logs();
    mdl_nbytes = 12; mdl_same = 0;
    set_req(1, 24'h0BEEF0, 14'd16);
    reqs_left[1] = 1;
    wait_done(1, 400, ok);
    n_cmp++;
    if (!ok || dat_q.size() != 12) begin n_fail++; $display("FAIL short_nbytes got=%0d want=12", dat_q.size()); end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0].idx != 1 || done_q[0].err !== 1'b1) begin
      n_fail++; $display("FAIL short_err n=%0d want one done on req 1 err 1", done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [55:0] outs;
    logic [13:0] n0, n1;
    clear_logs();
    mdl_nbytes = -1; mdl_same = 0;
    set_req(0, 24'h555555, 14'd16);
    reqs_left[0] = 1;
    ok = 0;
    repeat (300) begin
      @(negedge clk);
      if (dat_q.size() >= 5) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL midreset_reach_byte5 got=%0d want=5", dat_q.size()); end
    #2 reset = 1'b1;
    #1;
    outs = {req_ack, req_data, req_data_valid, req_done, req_err, busy,
            fl_addr, fl_byte_count, fl_start};
    n_cmp++;
    if (outs !== '0) begin n_fail++; $display("FAIL midreset_outputs got=%h want=0", outs); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    clear_logs();
    n0 = 14'($urandom_range(1, 10)); n1 = 14'($urandom_range(1, 10));
    set_req(0, 24'h010203, n0);
    set_req(1, 24'h040506, n1);
    reqs_left[0] = 1; reqs_left[1] = 1;
    wait_done(2, 600, ok);
    n_cmp++;
    if (!ok || ack_q.size() != 2 || ack_q[0].idx != 0 || ack_q[1].idx != 1) begin
      n_fail++; $display("FAIL midreset_regrant acks=%0d first=%0d want 2 acks, 0 then 1", ack_q.size(), (ack_q.size() > 0) ? ack_q[0].idx : -1);
    end
    n_cmp++;
    if (done_q.size() != 2 || done_q[1].idx != 1 || done_q[0].err !== 1'b0 || done_q[1].err !== 1'b0 || dat_q.size() != int'(n0) + int'(n1)) begin
      n_fail++; $display("FAIL midreset_clean dones=%0d bytes=%0d want 2/%0d no err", done_q.size(), dat_q.size(), int'(n0) + int'(n1));
    end
  endtask

  task automatic test_random();
    bit ok;
    int r, nb;
    logic [23:0] a;
    logic [13:0] c;
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      r = $urandom_range(0, NREQ - 1);
      a = 24'($urandom);
      c = 14'($urandom_range(1, 24));
      nb = ($urandom_range(0, 1) == 0) ? int'(c) : $urandom_range(0, int'(c) + 3);
      mdl_nbytes = nb;
      mdl_same = $urandom_range(0, 1);
      set_req(r, a, c);
      reqs_left[r] = 1;
      wait_done(1, 500, ok);
      n_cmp++;
      if (!ok || st_q.size() != 1 || ack_q.size() != 1 || ack_q[0].idx != r || st_q[0].a !== a || st_q[0].c !== c) begin
        n_fail++; $display("FAIL rand%0d_grant ok=%0d starts=%0d want req %0d addr %h count %0d", it, ok, st_q.size(), r, a, c);
      end
      n_cmp++;
      if (dat_q.size() != nb) begin n_fail++; $display("FAIL rand%0d_nbytes got=%0d want=%0d", it, dat_q.size(), nb); end
      for (int k = 0; k < dat_q.size() && k < exp_bytes.size(); k++) begin
        n_cmp++;
        if (dat_q[k].idx != r || dat_q[k].b !== exp_bytes[k]) begin
          n_fail++; $display("FAIL rand%0d_byte%0d got=%h@%0d want=%h@%0d", it, k, dat_q[k].b, dat_q[k].idx, exp_bytes[k], r);
        end
      end
      n_cmp++;
      if (done_q.size() != 1 || done_q[0].idx != r || done_q[0].err !== (nb != int'(c))) begin
        n_fail++; $display("FAIL rand%0d_done n=%0d want req %0d err %0d", it, done_q.size(), r, (nb != int'(c)));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_zero_count();
    test_timeout();
    test_short();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
